// File: rtl/alu_pipe_module.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Optional macro ALUPIPE_STICKY_FLAGS_EN adds sticky {V, err} status and a clear opcode.
module alu_pipe_module #(
  parameter int unsigned NB_ALUPIPE_DATA  = 8,
  parameter int unsigned NB_ALUPIPE_OP    = 6,
  parameter int unsigned NB_ALUPIPE_SHAMT = $clog2(NB_ALUPIPE_DATA)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_alupipe_valid,
  output logic                       o_alupipe_ready,
  input  logic [NB_ALUPIPE_DATA-1:0] i_alupipe_data_A,
  input  logic [NB_ALUPIPE_DATA-1:0] i_alupipe_data_B,
  input  logic [NB_ALUPIPE_OP-1:0]   i_alupipe_OP,
  output logic                       o_alupipe_valid,
  input  logic                       i_alupipe_ready,
  output logic [NB_ALUPIPE_DATA-1:0] o_alupipe_data_RES,
  output logic [3:0]                 o_alupipe_flags,
  output logic                       o_alupipe_err
`ifdef ALUPIPE_STICKY_FLAGS_EN
  ,
  output logic [1:0]                 o_alupipe_sticky
`endif
);

  localparam int unsigned MSB = NB_ALUPIPE_DATA - 1;

  localparam logic [NB_ALUPIPE_OP-1:0] OP_ADD = NB_ALUPIPE_OP'(6'b100000);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_SUB = NB_ALUPIPE_OP'(6'b100010);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_AND = NB_ALUPIPE_OP'(6'b100100);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_OR  = NB_ALUPIPE_OP'(6'b100101);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_XOR = NB_ALUPIPE_OP'(6'b100110);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_NOR = NB_ALUPIPE_OP'(6'b100111);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_SRA = NB_ALUPIPE_OP'(6'b000011);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_SRL = NB_ALUPIPE_OP'(6'b000010);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_SLL = NB_ALUPIPE_OP'(6'b000000);
  localparam logic [NB_ALUPIPE_OP-1:0] OP_SLT = NB_ALUPIPE_OP'(6'b101010);
`ifdef ALUPIPE_STICKY_FLAGS_EN
  localparam logic [NB_ALUPIPE_OP-1:0] OP_CLR = NB_ALUPIPE_OP'(6'b111111);
`endif

  // Stage 1 registers
  logic                       s1_valid_q, s1_valid_d;
  logic [NB_ALUPIPE_DATA-1:0] a_q, a_d;
  logic [NB_ALUPIPE_DATA-1:0] b_q, b_d;
  logic [NB_ALUPIPE_OP-1:0]   op_q, op_d;

  // Stage 2 registers
  logic                       s2_valid_q, s2_valid_d;
  logic [NB_ALUPIPE_DATA-1:0] res_q, res_d;
  logic [3:0]                 flags_q, flags_d;
  logic                       err_q, err_d;

  logic s1_adv, s2_adv, in_hs;

  logic [NB_ALUPIPE_DATA:0]    add_w, sub_w;
  logic [NB_ALUPIPE_SHAMT-1:0] shamt;
  logic [NB_ALUPIPE_DATA-1:0]  res_c;
  logic [3:0]                  flags_c;
  logic                        carry_c, ovf_c, err_c;

  // Handshake / advance logic
  always_comb begin : adv_logic
    s2_adv          = !s2_valid_q || i_alupipe_ready;
    s1_adv          = !s1_valid_q || s2_adv;
    in_hs           = i_alupipe_valid && s1_adv;
    o_alupipe_ready = s1_adv;
  end

  // ALU datapath evaluated on the stage-1 operands
  always_comb begin : alu_calc
    add_w   = {1'b0, a_q} + {1'b0, b_q};
    sub_w   = {1'b0, a_q} - {1'b0, b_q};
    shamt   = b_q[NB_ALUPIPE_SHAMT-1:0];
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    err_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_c   = add_w[MSB:0];
        carry_c = add_w[NB_ALUPIPE_DATA];
        ovf_c   = (a_q[MSB] == b_q[MSB]) && (add_w[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res_c   = sub_w[MSB:0];
        carry_c = sub_w[NB_ALUPIPE_DATA];
        ovf_c   = (a_q[MSB] != b_q[MSB]) && (sub_w[MSB] != a_q[MSB]);
      end
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_XOR: res_c = a_q ^ b_q;
      OP_NOR: res_c = ~(a_q | b_q);
      OP_SRA: res_c = $unsigned($signed(a_q) >>> shamt);
      OP_SRL: res_c = a_q >> shamt;
      OP_SLL: res_c = a_q << shamt;
      OP_SLT: res_c = {{(NB_ALUPIPE_DATA-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
`ifdef ALUPIPE_STICKY_FLAGS_EN
      OP_CLR: res_c = '0;
`endif
      default: err_c = 1'b1;
    endcase
    flags_c = {res_c[MSB], (res_c == '0), carry_c, ovf_c};
`ifdef ALUPIPE_STICKY_FLAGS_EN
    // The clear op reports all-zero flags, including Z
    if (op_q == OP_CLR) flags_c = '0;
`endif
  end

  always_comb begin : next_state
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    flags_d    = flags_q;
    err_d      = err_q;
    if (s1_adv) s1_valid_d = i_alupipe_valid;
    if (in_hs) begin
      a_d  = i_alupipe_data_A;
      b_d  = i_alupipe_data_B;
      op_d = i_alupipe_OP;
    end
    // Result registers only change when a new transaction moves into stage 2
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d   = res_c;
        flags_d = flags_c;
        err_d   = err_c;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : pipe_regs
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
    end
  end

  assign o_alupipe_valid    = s2_valid_q;
  assign o_alupipe_data_RES = res_q;
  assign o_alupipe_flags    = flags_q;
  assign o_alupipe_err      = err_q;

`ifdef ALUPIPE_STICKY_FLAGS_EN
  logic       out_hs;
  logic [1:0] sticky_q, sticky_d;

  // A clear op accepted this cycle wins over a result leaving in the same cycle
  always_comb begin : sticky_next
    out_hs   = s2_valid_q && i_alupipe_ready;
    sticky_d = sticky_q;
    if (in_hs && (i_alupipe_OP == OP_CLR)) sticky_d = '0;
    else if (out_hs)                       sticky_d = sticky_q | {flags_q[0], err_q};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : sticky_reg
    if (!i_rst_n) sticky_q <= '0;
    else          sticky_q <= sticky_d;
  end

  assign o_alupipe_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_pipe_module.sv
// Bench for alu_pipe_module: directed table, back-pressure, reset and random stream
// checked against an integer-arithmetic reference model with an in-order scoreboard.
module tb_alu_pipe_module;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, o_ready, o_valid, out_ready;
  logic [7:0] in_a, in_b, o_res;
  logic [5:0] in_op;
  logic [3:0] o_flags;
  logic       o_err;
`ifdef ALUPIPE_STICKY_FLAGS_EN
  logic [1:0] o_sticky;
  logic [1:0] sticky_m = 2'b00;
`endif

  always #5 clk = ~clk;

  alu_pipe_module dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_alupipe_valid    (in_valid),
    .o_alupipe_ready    (o_ready),
    .i_alupipe_data_A   (in_a),
    .i_alupipe_data_B   (in_b),
    .i_alupipe_OP       (in_op),
    .o_alupipe_valid    (o_valid),
    .i_alupipe_ready    (out_ready),
    .o_alupipe_data_RES (o_res),
    .o_alupipe_flags    (o_flags),
    .o_alupipe_err      (o_err)
`ifdef ALUPIPE_STICKY_FLAGS_EN
    ,
    .o_alupipe_sticky   (o_sticky)
`endif
  );

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    logic       err;
    int         cyc;
    int         id;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    logic [3:0] fl;
    logic       err;
  } vec_t;

  exp_t q[$];
  vec_t tab [16];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int id_ctr = 0;
  logic [5:0] ops [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                           6'b100111, 6'b000011, 6'b000010, 6'b000000, 6'b101010};

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s id=%0d got=%0h expected=%0h", name, id, act, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic
  function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                                  output logic [7:0] res, output logic [3:0] fl, output logic err);
    int sa, sb, ua, ub, r, sh;
    logic c, v;
    sa = int'($signed(a)); sb = int'($signed(b));
    ua = int'(a);          ub = int'(b);
    sh = ub % 8;
    r = 0; c = 1'b0; v = 1'b0; err = 1'b0;
    case (op)
      6'b100000: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      6'b100010: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = ~(ua | ub);
      6'b000011: r = sa >>> sh;
      6'b000010: r = ua >> sh;
      6'b000000: r = ua << sh;
      6'b101010: r = (sa < sb) ? 1 : 0;
`ifdef ALUPIPE_STICKY_FLAGS_EN
      6'b111111: begin res = 8'h00; fl = 4'b0000; err = 1'b0; return; end
`endif
      default: err = 1'b1;
    endcase
    res = 8'(r);
    fl  = {res[7], (res == 8'h00), c, v};
  endfunction

  // One clock cycle: drive, check against scoreboard, then book-keep the handshakes
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                      input logic rdy, input logic use_tab, input logic [7:0] tres,
                      input logic [3:0] tfl, input logic terr, output logic acc);
    exp_t e;
    logic hs_out, exp_v;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = rdy;
    #1;
    exp_v = (q.size() > 0) && (cyc > q[0].cyc);
    chk("out_valid", id_ctr, 32'(o_valid), 32'(exp_v));
    chk("in_ready", id_ctr, 32'(o_ready), 32'((q.size() < 2) || rdy));
    if (o_valid && exp_v) begin
      chk("res", q[0].id, 32'(o_res), 32'(q[0].res));
      chk("flags", q[0].id, 32'(o_flags), 32'(q[0].fl));
      chk("err", q[0].id, 32'(o_err), 32'(q[0].err));
    end
`ifdef ALUPIPE_STICKY_FLAGS_EN
    chk("sticky", id_ctr, 32'(o_sticky), 32'(sticky_m));
`endif
    acc    = v && o_ready;
    hs_out = o_valid && rdy;
    @(posedge clk);
    cyc++;
    if (hs_out && q.size() > 0) begin
`ifdef ALUPIPE_STICKY_FLAGS_EN
      sticky_m = sticky_m | {q[0].fl[0], q[0].err};
`endif
      void'(q.pop_front());
    end
    if (acc) begin
      if (use_tab) begin e.res = tres; e.fl = tfl; e.err = terr; end
      else ref_alu(a, b, op, e.res, e.fl, e.err);
      e.cyc = cyc;
      e.id  = id_ctr++;
      q.push_back(e);
`ifdef ALUPIPE_STICKY_FLAGS_EN
      if (op == 6'b111111) sticky_m = 2'b00;
`endif
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 6'b000000, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, acc);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic acc;
    step(1'b1, a, b, op, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, acc);
    chk("issue_acc", id_ctr, 32'(acc), 32'd1);
  endtask

  initial begin
    logic acc;
    logic saw_low;
    int   idx;
    logic [7:0] ra, rb;
    logic [5:0] rop;
    logic rv, rr;

    tab[0]  = '{8'h7F, 8'h01, 6'b100000, 8'h80, 4'b1001, 1'b0};
    tab[1]  = '{8'hFF, 8'h01, 6'b100000, 8'h00, 4'b0110, 1'b0};
    tab[2]  = '{8'h05, 8'h05, 6'b100010, 8'h00, 4'b0100, 1'b0};
    tab[3]  = '{8'h01, 8'h02, 6'b100010, 8'hFF, 4'b1010, 1'b0};
    tab[4]  = '{8'h80, 8'h01, 6'b100010, 8'h7F, 4'b0001, 1'b0};
    tab[5]  = '{8'hF0, 8'h3C, 6'b100100, 8'h30, 4'b0000, 1'b0};
    tab[6]  = '{8'hF0, 8'h0F, 6'b100101, 8'hFF, 4'b1000, 1'b0};
    tab[7]  = '{8'hAA, 8'hFF, 6'b100110, 8'h55, 4'b0000, 1'b0};
    tab[8]  = '{8'h00, 8'h00, 6'b100111, 8'hFF, 4'b1000, 1'b0};
    tab[9]  = '{8'hF0, 8'h02, 6'b000011, 8'hFC, 4'b1000, 1'b0};
    tab[10] = '{8'hF0, 8'h02, 6'b000010, 8'h3C, 4'b0000, 1'b0};
    tab[11] = '{8'h81, 8'h09, 6'b000000, 8'h02, 4'b0000, 1'b0};
    tab[12] = '{8'hFE, 8'h01, 6'b101010, 8'h01, 4'b0000, 1'b0};
    tab[13] = '{8'h01, 8'hFE, 6'b101010, 8'h00, 4'b0100, 1'b0};
    tab[14] = '{8'h80, 8'hFF, 6'b000011, 8'hFF, 4'b1000, 1'b0};
    tab[15] = '{8'h12, 8'h34, 6'b111000, 8'h00, 4'b0100, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 6'b000000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 0, 32'(o_valid), 32'd0);
    chk("rst_ready", 0, 32'(o_ready), 32'd1);
    chk("rst_res", 0, 32'(o_res), 32'd0);
    chk("rst_flags", 0, 32'(o_flags), 32'd0);
    chk("rst_err", 0, 32'(o_err), 32'd0);

    // Directed table: one op at a time, result expected exactly two cycles later
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tab[i].a, tab[i].b, tab[i].op, 1'b1, 1'b1, tab[i].res, tab[i].fl, tab[i].err, acc);
      chk("tab_acc", i, 32'(acc), 32'd1);
      idle(2);
    end

    // Back-pressure: six ops, downstream not ready in cycles 3-5
    idx = 0; saw_low = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step(idx < 6, 8'(8'h30 + idx * 8'h11), 8'(idx + 1), ops[idx % 10], !(c >= 3 && c <= 5),
           1'b0, 8'h00, 4'h0, 1'b0, acc);
      if (!o_ready) saw_low = 1'b1;
      if (acc) idx++;
    end
    chk("bp_all_accepted", 0, 32'(idx), 32'd6);
    chk("bp_ready_dropped", 0, 32'(saw_low), 32'd1);
    chk("bp_drained", 0, 32'(q.size()), 32'd0);

    // Full-rate stream with ready held high
    for (int i = 0; i < 8; i++) issue(8'($urandom), 8'($urandom), ops[i]);
    idle(3);

    // Reset with two ops in flight
    issue(8'h11, 8'h22, 6'b100000);
    issue(8'h33, 8'h44, 6'b100010);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 0, 32'(o_valid), 32'd0);
    chk("midrst_res", 0, 32'(o_res), 32'd0);
    chk("midrst_ready", 0, 32'(o_ready), 32'd1);
    q.delete();
`ifdef ALUPIPE_STICKY_FLAGS_EN
    sticky_m = 2'b00;
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

`ifdef ALUPIPE_STICKY_FLAGS_EN
    issue(8'h00, 8'h00, 6'b111111);
    issue(8'h7F, 8'h01, 6'b100000);
    issue(8'h0F, 8'h03, 6'b100100);
    idle(3);
    chk("sticky_v_held", 0, 32'(o_sticky), 32'd2);
    issue(8'h00, 8'h00, 6'b111111);
    idle(3);
    chk("sticky_cleared", 0, 32'(o_sticky), 32'd0);
`endif

    // Random stream with random back-pressure
    for (int i = 0; i < 1500; i++) begin
      rv  = ($urandom_range(0, 9) < 7);
      rr  = ($urandom_range(0, 9) < 6);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      step(rv, ra, rb, rop, rr, 1'b0, 8'h00, 4'h0, 1'b0, acc);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
    chk("final_drain", 0, 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
